// File: rtl/cla_16bit_pkg.sv
// ============================================================================
// Module : cla_16bit_pkg
// Brief  : Shared widths and carry-lookahead equations for the 16-bit CLA.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cla_16bit_pkg;

    localparam int WIDTH   = 16;
    localparam int GROUP   = 4;
    localparam int NGROUPS = 4;

    // Carries into positions 0..3 of a 4-wide lookahead block, fully flattened.
    function automatic logic [GROUP-1:0] lookahead_carries(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c0
    );
        logic [GROUP-1:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic group_propagate(input logic [GROUP-1:0] p);
        return &p;
    endfunction

    function automatic logic group_generate(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_16bit_cla_4bit.sv
// ============================================================================
// Module : cla_4bit
// Brief  : 4-bit lookahead group producing sum bits and group P/G.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_4bit
    import cla_16bit_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p_g,
    output logic             g_g
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_c;

    always_comb begin
        w_p = a ^ b;
        w_g = a & b;
        w_c = lookahead_carries(w_p, w_g, cin);
        s   = w_p ^ w_c;
        p_g = group_propagate(w_p);
        g_g = group_generate(w_p, w_g);
    end

endmodule

`default_nettype wire

// File: rtl/cla_16bit.sv
// ============================================================================
// Module : cla_16bit
// Brief  : Registered 16-bit two-level carry-lookahead adder with group P/G.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_16bit
    import cla_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             PG,
    output logic             GG
);

    logic [WIDTH-1:0]   w_sum;
    logic [NGROUPS-1:0] w_grp_p;
    logic [NGROUPS-1:0] w_grp_g;
    logic [NGROUPS-1:0] w_grp_c;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             pg_d, pg_q;
    logic             gg_d, gg_q;

    for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
        cla_4bit u_cla_4bit (
            .a   (A[gi*GROUP +: GROUP]),
            .b   (B[gi*GROUP +: GROUP]),
            .cin (w_grp_c[gi]),
            .s   (w_sum[gi*GROUP +: GROUP]),
            .p_g (w_grp_p[gi]),
            .g_g (w_grp_g[gi])
        );
    end

    // Second level reuses the group equations on group P/G; C16 = GG | PG*Cin.
    always_comb begin
        w_grp_c = lookahead_carries(w_grp_p, w_grp_g, Cin);
        pg_d    = group_propagate(w_grp_p);
        gg_d    = group_generate(w_grp_p, w_grp_g);
        cout_d  = gg_d | (pg_d & Cin);
        s_d     = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            pg_q   <= 1'b0;
            gg_q   <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            pg_q   <= pg_d;
            gg_q   <= gg_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign PG   = pg_q;
    assign GG   = gg_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_16bit.sv
// ============================================================================
// Module : tb_cla_16bit
// Brief  : Scoreboard bench for cla_16bit: directed vectors plus random run.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cla_16bit;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        pg;
        logic        gg;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;
    logic        PG;
    logic        GG;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    cla_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .PG   (PG),
        .GG   (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".S"},    S,            16'h0000);
        check({name, ".Cout"}, {15'd0, Cout}, 16'd0);
        check({name, ".PG"},   {15'd0, PG},   16'd0);
        check({name, ".GG"},   {15'd0, GG},   16'd0);
    endtask

    // Push a hand-computed expectation for operands driven at this negedge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic epg,
                         input logic egg, input string name);
        exp_t e;
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        e.s = es; e.cout = ec; e.pg = epg; e.gg = egg; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: result of operands from the previous negedge is visible after this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".S"},    S,             e.s);
                check({e.name, ".Cout"}, {15'd0, Cout}, {15'd0, e.cout});
                check({e.name, ".PG"},   {15'd0, PG},   {15'd0, e.pg});
                check({e.name, ".GG"},   {15'd0, GG},   {15'd0, e.gg});
            end
        end
    end

    initial begin
        logic [16:0] full;
        logic [16:0] gen;
        exp_t        e;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        A     = 16'h0;
        B     = 16'h0;
        Cin   = 1'b0;

        // Reset before any clock edge must clear outputs on its own.
        #3;
        rst = 1'b1;
        A   = 16'h1234;
        B   = 16'hfedc;
        Cin = 1'b1;
        #1;
        check_zero("reset_async");

        @(negedge clk);
        rst = 1'b0;

        apply(16'h5aa5, 16'ha55a, 1'b0, 16'hffff, 1'b0, 1'b1, 1'b0, "compl_5aa5");
        apply(16'h1010, 16'h0101, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, "compl_1010");
        apply(16'h00f1, 16'h001f, 1'b1, 16'h0111, 1'b0, 1'b0, 1'b0, "cin_00f1");
        apply(16'habe2, 16'hcd2e, 1'b0, 16'h7910, 1'b1, 1'b0, 1'b1, "cout_abe2");
        apply(16'hff13, 16'hff31, 1'b0, 16'hfe44, 1'b1, 1'b0, 1'b1, "cout_ff13");
        apply(16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "prop_cin1");
        apply(16'hffff, 16'h0000, 1'b0, 16'hffff, 1'b0, 1'b1, 1'b0, "prop_cin0");
        apply(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "zero");
        apply(16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1, 1'b0, 1'b1, "max_all");

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            A   = 16'($urandom);
            B   = 16'($urandom);
            Cin = 1'($urandom);
            full = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
            gen  = {1'b0, A} + {1'b0, B};
            if (i == 5000 || i == 5001) begin
                rst = 1'b1;
                e.s = 16'h0; e.cout = 1'b0; e.pg = 1'b0; e.gg = 1'b0; e.name = "rnd_in_reset";
            end else begin
                rst = 1'b0;
                e.s = full[15:0]; e.cout = full[16]; e.pg = ((A ^ B) == 16'hffff);
                e.gg = gen[16]; e.name = "rnd";
            end
            sb.push_back(e);
            if (i == 5000) begin
                #1;
                check_zero("reset_midrun_async");
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
